// File: rtl/pipe_skid_reg.sv
// -----------------------------------------------------------------------------
// pipe_skid_reg
//
// Purpose:
//   Pipeline stage register with a one-entry skid buffer.
//   - The main register drives out_data/out_valid.
//   - The skid register catches the single beat that can arrive in the cycle
//     where the downstream stops accepting.
//   Because of the skid entry, in_ready is fully registered and has no
//   combinational path from out_ready.
//
// Handshake (both sides):
//   A beat transfers on a rising clk edge where valid & ready are both 1.
//   - A producer holding valid keeps its data stable until the transfer.
//   - ready may be asserted whether or not valid is present.
//   - In this stage, in_ready depends only on registered occupancy.
//
// Optional feature:
//   `PIPE_SKID_REG_PERF_EN` enables two saturating performance counters
//   (stall_cycles, flush_count). When undefined, both outputs are constant 0
//   and no counter flops exist.
//
// Parameters:
//   DATA_W     : payload width
//   RESET_VAL  : out_data and skid contents after reset
//   BUBBLE_VAL : out_data after a flush
//
// Ports:
//   clk          : clock; all flops are rising-edge
//   reset        : asynchronous, active-high reset (wins over flush)
//   flush        : synchronous; discards all held and incoming beats
//   in_valid     : upstream beat present
//   in_ready     : stage can accept (registered)
//   in_data      : upstream payload
//   out_valid    : downstream beat present (registered)
//   out_ready    : downstream accepts
//   out_data     : downstream payload (registered)
//   stall_cycles : count of cycles with out_valid=1 & out_ready=0
//   flush_count  : count of flushes that discarded something
//   state_dbg    : occupancy state (0=EMPTY, 1=ONE, 2=TWO) for observation
// -----------------------------------------------------------------------------
module pipe_skid_reg #(
    parameter int unsigned          DATA_W     = 64,
    parameter logic [DATA_W-1:0]    RESET_VAL  = {DATA_W{1'b0}},
    parameter logic [DATA_W-1:0]    BUBBLE_VAL = {DATA_W{1'b0}}
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [31:0]       stall_cycles,
    output logic [31:0]       flush_count,
    output logic [1:0]        state_dbg
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] main_d;
    logic [DATA_W-1:0] skid_q;
    logic [DATA_W-1:0] skid_d;
    logic              out_valid_q;
    logic              in_ready_q;
    logic              in_fire;
    logic              out_fire;

    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = out_valid_q & out_ready;

    // -------------------------------------------------------------------------
    // Next-state / datapath
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        if (flush) begin
            // Anything held or firing this cycle is dropped. The skid entry
            // is invalidated through the state; its contents are don't-care.
            state_d = EMPTY;
            main_d  = BUBBLE_VAL;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d = ONE;
                        main_d  = in_data;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data;
                    end else if (in_fire) begin
                        // Downstream stalled: park the new beat in the skid.
                        state_d = TWO;
                        skid_d  = in_data;
                    end else if (out_fire) begin
                        // main keeps its last value while EMPTY.
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (out_fire) begin
                        state_d = ONE;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // State and data registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= EMPTY;
            main_q      <= RESET_VAL;
            skid_q      <= RESET_VAL;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            // Handshake flags are registered images of the next occupancy.
            out_valid_q <= (state_d != EMPTY);
            in_ready_q  <= (state_d != TWO);
        end
    end

    assign out_data  = main_q;
    assign out_valid = out_valid_q;
    assign in_ready  = in_ready_q;
    assign state_dbg = state_q;

    // -------------------------------------------------------------------------
    // Performance counters
    // -------------------------------------------------------------------------
`ifdef PIPE_SKID_REG_PERF_EN
    logic [31:0] stall_q;
    logic [31:0] flush_cnt_q;
    logic        stall_evt;
    logic        flush_evt;

    assign stall_evt = out_valid_q & ~out_ready;
    // Only count flushes that actually discarded something.
    assign flush_evt = flush & ((state_q != EMPTY) | in_fire);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q     <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            if (stall_evt && (stall_q != 32'hFFFF_FFFF)) begin
                stall_q <= stall_q + 32'd1;
            end
            if (flush_evt && (flush_cnt_q != 32'hFFFF_FFFF)) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_cnt_q;
`else
    assign stall_cycles = 32'd0;
    assign flush_count  = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_skid_reg
//
// Directed test of pipe_skid_reg with DATA_W=8, distinct RESET_VAL and
// BUBBLE_VAL. Inputs change and outputs are sampled 1 time unit after the
// rising edge. Expected values are hand-computed per step.
// -----------------------------------------------------------------------------
module tb_pipe_skid_reg;

  localparam int unsigned DW = 8;
  localparam logic [DW-1:0] RST_V = 8'h5A;
  localparam logic [DW-1:0] BUB_V = 8'hEE;

`ifdef PIPE_SKID_REG_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [31:0]   stall_cycles;
  logic [31:0]   flush_count;
  logic [1:0]    state_dbg;

  int n_chk;
  int n_fail;

  pipe_skid_reg #(
    .DATA_W     (DW),
    .RESET_VAL  (RST_V),
    .BUBBLE_VAL (BUB_V)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count),
    .state_dbg    (state_dbg)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [DW-1:0] d,
                         input logic rdy, input logic [1:0] st);
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(v));
    chk({tag, ".out_data"},  64'(out_data),  64'(d));
    chk({tag, ".in_ready"},  64'(in_ready),  64'(rdy));
    chk({tag, ".state"},     64'(state_dbg), 64'(st));
  endtask

  task automatic pulse_reset();
    #2 reset = 1'b1;
    #1;
    chk_out("reset_pulse", 1'b0, RST_V, 1'b1, 2'd0);
    chk("reset_pulse.stall", 64'(stall_cycles), 64'd0);
    chk("reset_pulse.flushc", 64'(flush_count), 64'd0);
    #2 reset = 1'b0;
  endtask

  initial begin
    n_chk    = 0;
    n_fail   = 0;
    reset    = 1'b1;
    flush    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    out_ready= 1'b0;
    #1;
    // Reset state (asynchronous, before any clock edge)
    chk_out("reset", 1'b0, RST_V, 1'b1, 2'd0);
    chk("reset.stall", 64'(stall_cycles), 64'd0);
    chk("reset.flushc", 64'(flush_count), 64'd0);

    // Reset and flush together with an input: reset wins
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h77;
    tick();
    chk_out("reset_wins", 1'b0, RST_V, 1'b1, 2'd0);
    flush    = 1'b0;
    in_valid = 1'b0;
    #2 reset = 1'b0;

    // Streaming: 1,2,3,4 back-to-back with out_ready high
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_data = 8'(i);
      tick();
      chk_out($sformatf("stream%0d", i), 1'b1, 8'(i), 1'b1, 2'd1);
    end
    in_valid = 1'b0;
    tick();
    // Last value holds when going EMPTY by output fire
    chk_out("stream_drain", 1'b0, 8'h04, 1'b1, 2'd0);

    // Backpressure: 0xA then 0xB with out_ready low
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h0A;
    tick();
    chk_out("bp_one", 1'b1, 8'h0A, 1'b1, 2'd1);
    in_data = 8'h0B;
    tick();
    chk_out("bp_two", 1'b1, 8'h0A, 1'b0, 2'd2);
    in_data = 8'h0C;       // not accepted while full
    tick();
    chk_out("bp_hold", 1'b1, 8'h0A, 1'b0, 2'd2);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk_out("bp_deliver_b", 1'b1, 8'h0B, 1'b1, 2'd1);
    tick();
    chk_out("bp_empty", 1'b0, 8'h0B, 1'b1, 2'd0);
    chk("bp.stall", 64'(stall_cycles), PERF ? 64'd2 : 64'd0);

    // Reset between sections clears counters
    pulse_reset();

    // Flush from TWO with an incoming beat; 5 stall cycles beforehand
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h0A;
    tick();
    in_data = 8'h0B;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk_out("fl_pre", 1'b1, 8'h0A, 1'b0, 2'd2);
    chk("fl_pre.stall", 64'(stall_cycles), PERF ? 64'd5 : 64'd0);
    flush     = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h0C;
    out_ready = 1'b1;      // an output fire this cycle is discarded too
    tick();
    chk_out("fl_post", 1'b0, BUB_V, 1'b1, 2'd0);
    chk("fl_post.stall", 64'(stall_cycles), PERF ? 64'd5 : 64'd0);
    chk("fl_post.flushc", 64'(flush_count), PERF ? 64'd1 : 64'd0);
    flush    = 1'b0;
    in_valid = 1'b0;
    tick();
    tick();
    chk_out("fl_quiet", 1'b0, BUB_V, 1'b1, 2'd0);

    // Flush while EMPTY with no input: not counted
    flush = 1'b1;
    tick();
    chk("fl_idle.flushc", 64'(flush_count), PERF ? 64'd1 : 64'd0);
    // Flush while EMPTY with an input firing: counted, beat discarded
    in_valid = 1'b1;
    in_data  = 8'h33;
    tick();
    chk_out("fl_in", 1'b0, BUB_V, 1'b1, 2'd0);
    chk("fl_in.flushc", 64'(flush_count), PERF ? 64'd2 : 64'd0);
    flush = 1'b0;

    // Normal beat after flush
    in_data = 8'h0D;
    tick();
    chk_out("after_fl", 1'b1, 8'h0D, 1'b1, 2'd1);

    // Asynchronous reset mid-operation in state ONE
    in_valid  = 1'b0;
    out_ready = 1'b0;
    pulse_reset();

    // First beat after reset is accepted normally
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h0E;
    tick();
    chk_out("post_reset", 1'b1, 8'h0E, 1'b1, 2'd1);
    in_valid = 1'b0;
    tick();
    chk_out("post_reset_drain", 1'b0, 8'h0E, 1'b1, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 Parameters (name, default, meaning): DATA_W, 64, payload width (e.g. {instruction, PC+4}); RESET_VAL, {DATA_W{1'b0}}, out_data value after reset; BUBBLE_VAL, {DATA_W{1'b0}}, out_data value after flush.
REQ-002 clk  input  1  single clock; all flops rising-edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 flush  input  1  synchronous; discard all held and incoming beats.
REQ-005 in_valid  input  1  upstream beat present.
REQ-006 in_ready  output  1  stage can accept; registered, no combinational path from out_ready.
REQ-007 in_data  input  DATA_W  upstream payload.
REQ-008 out_valid  output  1  downstream beat present; registered.
REQ-009 out_ready  input  1  downstream accepts (replaces stall: stall = !out_ready).
REQ-010 out_data  output  DATA_W  downstream payload; registered.
REQ-011 stall_cycles  output  32  perf counter (see Configuration).
REQ-012 flush_count  output  32  perf counter (see Configuration).

Function
REQ-013 Storage: one main register (drives out_data/out_valid) plus one skid register; occupancy states EMPTY, ONE, TWO.
REQ-014 Input fire = in_valid & in_ready; output fire = out_valid & out_ready.
REQ-015 in_ready SHALL be 1 exactly when state != TWO.
REQ-016 EMPTY: in fire -> ONE, main <= in_data; else stay.
REQ-017 ONE: in fire & out fire -> ONE, main <= in_data; in fire only -> TWO, skid <= in_data; out fire only -> EMPTY; neither -> stay.
REQ-018 TWO: out fire -> ONE, main <= skid; else stay; no input accepted.
REQ-019 Latency: accepted beat appears on out_data the next cycle when stage was EMPTY or ONE with out fire; throughput one beat/cycle with out_ready held high.
REQ-020 Ordering: beats leave in acceptance order; no beat duplicated or dropped except by flush.
REQ-021 While out_valid=1 and out_ready=0, out_data SHALL stay unchanged.
REQ-022 out_data SHALL hold its last value when going EMPTY by output fire.
REQ-023 flush has priority over all handshakes: next state EMPTY, out_valid <= 0, out_data <= BUBBLE_VAL, skid invalidated, in_ready <= 1; any beat firing in that cycle is discarded.
REQ-024 flush and reset both asserted: reset wins.

Reset
REQ-025 reset assertion SHALL immediately (asynchronously) force state EMPTY, out_valid=0, in_ready=1, out_data=RESET_VAL, skid contents RESET_VAL, counters 0.
REQ-026 Reset mid-transfer discards all held beats; first beat after deassertion is accepted normally.

Configuration
REQ-027 Macro PIPE_SKID_REG_PERF_EN: when defined, stall_cycles increments each cycle with out_valid=1 & out_ready=0, flush_count increments each flush cycle in which state != EMPTY or an input fires; both saturate at 32'hFFFF_FFFF and clear only on reset.
REQ-028 When PIPE_SKID_REG_PERF_EN is undefined, stall_cycles and flush_count SHALL be constant 0 with no counter flops; all other behaviour is identical.

Verification
REQ-029 Streaming: out_ready=1, in_valid=1 with data 1,2,3,4 on consecutive cycles -> out_data 1,2,3,4 on the following four cycles, in_ready constantly 1.
REQ-030 Backpressure: send 0xA, 0xB with out_ready=0 -> state TWO, in_ready=0, out_data=0xA held; raise out_ready -> 0xA then 0xB delivered, in_ready returns to 1 after first output fire.
REQ-031 Flush: state TWO holding 0xA/0xB, flush=1 with in_valid=1 data 0xC -> next cycle out_valid=0, out_data=BUBBLE_VAL, in_ready=1; 0xA, 0xB, 0xC never appear.
REQ-032 Async reset mid-operation: assert reset between clock edges in state ONE -> out_valid drops to 0 and out_data=RESET_VAL before next edge.
REQ-033 Perf (macro defined): 5 cycles out_valid=1, out_ready=0 then one flush with held data -> stall_cycles=5, flush_count=1; macro undefined -> both 0.
REQ-034 Random valid/ready (10k cycles, DATA_W=8 and 64) vs scoreboard FIFO model -> zero mismatches, ordering and no-loss per REQ-020.
